// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: Floyd cycle detection sequencer for the GRN node array.
// It loads a seed into the nodes, then steps the hare (s1) and tortoise (s0)
// until they meet. After that it freezes the tortoise and steps only the hare
// to measure the attractor period. Every output is registered, so pulses are
// set on the edge that enters the state they belong to.
module gnr_attractor_ctrl #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_NODES-1:0] in_seed,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_NODES-1:0] out_seed,
  output logic [CNT_W-1:0]     out_meet,
  output logic [CNT_W-1:0]     out_period,
  output logic                 out_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HSTEP = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_CMP1  = 3'd4;
  localparam logic [2:0] S_STEP2 = 3'd5;
  localparam logic [2:0] S_CMP2  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

  logic [2:0]           r_state;
  logic [NUM_NODES-1:0] r_seed;
  logic [NUM_NODES-1:0] r_init_state;
  logic [CNT_W-1:0]     r_t;
  logic [CNT_W-1:0]     r_p;
  logic [CNT_W-1:0]     r_out_meet;
  logic [CNT_W-1:0]     r_out_period;
  logic                 r_out_timeout;
  logic                 r_out_valid;
  logic                 r_in_ready;
  logic                 r_reset_nos;
  logic                 r_start_s0;
  logic                 r_start_s1;
  logic                 w_eq;

  // Node outputs are settled during the compare states.
  assign w_eq = (s0_vec == s1_vec);

  // Sequencer: state, counters and every registered output. Pulses default
  // low and are raised only on the edge that enters their state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_seed        <= '0;
      r_init_state  <= '0;
      r_t           <= '0;
      r_p           <= '0;
      r_out_meet    <= '0;
      r_out_period  <= '0;
      r_out_timeout <= 1'b0;
      r_out_valid   <= 1'b0;
      r_in_ready    <= 1'b0;
      r_reset_nos   <= 1'b0;
      r_start_s0    <= 1'b0;
      r_start_s1    <= 1'b0;
    end else begin
      r_reset_nos <= 1'b0;
      r_start_s0  <= 1'b0;
      r_start_s1  <= 1'b0;
      r_in_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_seed        <= in_seed;
            r_init_state  <= in_seed;
            r_reset_nos   <= 1'b1;
            r_out_meet    <= '0;
            r_out_period  <= '0;
            r_out_timeout <= 1'b0;
            r_state       <= S_LOAD;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          r_t        <= '0;
          r_start_s1 <= 1'b1;
          r_state    <= S_HSTEP;
        end
        // Hare-only first step leaves the tortoise one lag behind.
        S_HSTEP: begin
          r_t     <= {{(CNT_W-1){1'b0}}, 1'b1};
          r_state <= S_CMP1;
        end
        S_STEP: begin
          r_t     <= r_t + 1'b1;
          r_state <= S_CMP1;
        end
        S_CMP1: begin
          if (w_eq) begin
            r_out_meet <= r_t;
            r_p        <= '0;
            r_start_s1 <= 1'b1;
            r_state    <= S_STEP2;
          end else if (r_t == MAX_C) begin
            r_out_meet    <= r_t;
            r_out_period  <= '0;
            r_out_timeout <= 1'b1;
            r_out_valid   <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_start_s0 <= 1'b1;
            r_start_s1 <= 1'b1;
            r_state    <= S_STEP;
          end
        end
        // Tortoise frozen; count hare steps around the cycle.
        S_STEP2: begin
          r_p     <= r_p + 1'b1;
          r_state <= S_CMP2;
        end
        S_CMP2: begin
          if (w_eq) begin
            r_out_period  <= r_p;
            r_out_timeout <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= S_DONE;
          end else if (r_p == MAX_C) begin
            r_out_period  <= '0;
            r_out_timeout <= 1'b1;
            r_out_valid   <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_start_s1 <= 1'b1;
            r_state    <= S_STEP2;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign reset_nos   = r_reset_nos;
  assign init_state  = r_init_state;
  assign start_s0    = r_start_s0;
  assign start_s1    = r_start_s1;
  assign out_valid   = r_out_valid;
  assign out_seed    = r_seed;
  assign out_meet    = r_out_meet;
  assign out_period  = r_out_period;
  assign out_timeout = r_out_timeout;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: two instances (default bound and a bound of 10)
// each driving a behavioural node array whose next-state function is selected
// by 'mode'. Expected results come from a direct Floyd reference model.
module tb_gnr_attractor_ctrl;
  localparam int N  = 3;
  localparam int CW = 16;

  typedef struct {
    logic [N-1:0] seed;
    int           meet;
    int           per;
    bit           to;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic          iv[2]    = '{1'b0, 1'b0};
  logic          ir[2];
  logic [N-1:0]  iseed[2] = '{3'd0, 3'd0};
  logic          rn[2];
  logic [N-1:0]  ist[2];
  logic          ss0[2];
  logic          ss1[2];
  logic [N-1:0]  s0v[2]   = '{3'd0, 3'd0};
  logic [N-1:0]  s1v[2]   = '{3'd0, 3'd0};
  logic          pass[2]  = '{1'b1, 1'b1};
  logic          ov[2];
  logic          ordy[2]  = '{1'b0, 1'b0};
  logic [N-1:0]  oseed[2];
  logic [CW-1:0] omeet[2];
  logic [CW-1:0] oper[2];
  logic          oto[2];

  always #5 clk = ~clk;

  gnr_attractor_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(65535)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_seed(iseed[0]),
    .reset_nos(rn[0]), .init_state(ist[0]), .start_s0(ss0[0]), .start_s1(ss1[0]),
    .s0_vec(s0v[0]), .s1_vec(s1v[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_seed(oseed[0]), .out_meet(omeet[0]), .out_period(oper[0]), .out_timeout(oto[0]));

  gnr_attractor_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(10)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_seed(iseed[1]),
    .reset_nos(rn[1]), .init_state(ist[1]), .start_s0(ss0[1]), .start_s1(ss1[1]),
    .s0_vec(s0v[1]), .s1_vec(s1v[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_seed(oseed[1]), .out_meet(omeet[1]), .out_period(oper[1]), .out_timeout(oto[1]));

  function automatic logic [N-1:0] nxt(input int md, input logic [N-1:0] x);
    case (md)
      0:       return x;
      1:       return x + 3'd1;
      default: return (x < 3'd3) ? x + 3'd1 : 3'd1;
    endcase
  endfunction

  // Node array model: hare steps every pulse, tortoise every second pulse.
  for (genvar g = 0; g < 2; g++) begin : g_node
    always @(posedge clk) begin
      if (rn[g]) begin
        s0v[g]  <= ist[g];
        s1v[g]  <= ist[g];
        pass[g] <= 1'b1;
      end else begin
        if (ss1[g]) s1v[g] <= nxt(mode, s1v[g]);
        if (ss0[g]) begin
          if (pass[g]) s0v[g] <= nxt(mode, s0v[g]);
          pass[g] <= ~pass[g];
        end
      end
    end
  end

  function automatic logic [N-1:0] xat(input int md, input logic [N-1:0] seed, input int k);
    logic [N-1:0] x = seed;
    for (int i = 0; i < k; i++) x = nxt(md, x);
    return x;
  endfunction

  // Floyd reference: first t>=1 with x_t == x_(t/2), then the smallest p>=1
  // returning the hare to the frozen tortoise.
  function automatic void ref_floyd(input int md, input logic [N-1:0] seed, input int maxs,
                                    output int meet, output int per, output bit to);
    meet = 0; per = 0; to = 1'b0;
    for (int t = 1; t <= maxs; t++) begin
      if (xat(md, seed, t) == xat(md, seed, t / 2)) begin meet = t; break; end
      if (t == maxs) begin meet = t; to = 1'b1; end
    end
    if (!to) begin
      for (int p = 1; p <= maxs; p++) begin
        if (xat(md, seed, meet + p) == xat(md, seed, meet / 2)) begin per = p; break; end
        if (p == maxs) begin per = 0; to = 1'b1; end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic submit(input int d, input logic [N-1:0] seed);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!ir[d] && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_before_submit", 64'(ir[d]), 64'd1);
    iv[d] = 1'b1; iseed[d] = seed;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    ref_floyd(mode, seed, (d == 0) ? 65535 : 10, e.meet, e.per, e.to);
    e.seed = seed;
    // Cycles counted from the LOAD cycle (=1); 49 when the accept cycle is 1.
    e.cyc  = 2 + 2 * e.meet + 2 * e.per;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic collect(input int d, output exp_t e);
    int n = 0;
    while (n < 400) begin
      @(negedge clk); n++;
      if (ov[d]) break;
    end
    chk("out_valid_seen", 64'(ov[d]), 64'd1);
    e = (d == 0) ? qa.pop_front() : qb.pop_front();
    chk("latency_cycles", 64'(n), 64'(e.cyc));
    chk("out_seed", 64'(oseed[d]), 64'(e.seed));
    chk("out_meet", 64'(omeet[d]), 64'(e.meet));
    chk("out_period", 64'(oper[d]), 64'(e.per));
    chk("out_timeout", 64'(oto[d]), 64'(e.to));
    chk("in_ready_in_done", 64'(ir[d]), 64'd0);
  endtask

  task automatic release_out(input int d);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    @(negedge clk);
    chk("out_valid_dropped", 64'(ov[d]), 64'd0);
    chk("in_ready_after_done", 64'(ir[d]), 64'd1);
  endtask

  task automatic chk_reset_outs(input int d);
    chk("rst_in_ready", 64'(ir[d]), 64'd0);
    chk("rst_pulses", {61'd0, rn[d], ss0[d], ss1[d]}, 64'd0);
    chk("rst_init_state", 64'(ist[d]), 64'd0);
    chk("rst_out_valid", 64'(ov[d]), 64'd0);
    chk("rst_out_fields", {oseed[d], omeet[d], oper[d], oto[d]}, 64'd0);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs(0);
    chk_reset_outs(1);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(ir[0]), 64'd1);

    // Fixed point: meet 1, period 1.
    mode = 0;
    submit(0, 3'b101);
    collect(0, e);
    release_out(0);

    // Pure 8-cycle: meet 15, period 8, latency 48 from LOAD.
    mode = 1;
    submit(0, 3'd0);
    collect(0, e);
    release_out(0);

    // Same map against a bound of 10: timeout with meet 10, period 0.
    submit(1, 3'd0);
    collect(1, e);
    release_out(1);

    // Transient then 3-cycle.
    mode = 2;
    submit(0, 3'd0);
    collect(0, e);
    release_out(0);

    // Backpressure in DONE: everything frozen for 20 cycles.
    mode = 0;
    submit(0, 3'b110);
    collect(0, e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(ov[0]), 64'd1);
      chk("bp_in_ready", 64'(ir[0]), 64'd0);
      chk("bp_fields", {oseed[0], omeet[0], oper[0], oto[0]},
          {3'(e.seed), 16'(e.meet), 16'(e.per), e.to});
    end
    release_out(0);

    // Reset while in the period phase, then a clean rerun.
    mode = 1;
    submit(0, 3'd0);
    repeat (35) @(posedge clk);
    @(negedge clk);
    chk("in_step2_pulses", {62'd0, ss0[0], ss1[0]}, 64'd1);
    chk("in_ready_busy", 64'(ir[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs(0);
    void'(qa.pop_front());
    rst = 1'b1;
    submit(0, 3'd0);
    collect(0, e);
    release_out(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
